// File: rtl/pc_fetch_unit.sv
// Architectural PC owner: fetches the word at CurrentPC over req/ack, issues it over
// valid/ready, then advances to NextPC. Misaligned targets and fetch timeouts fault stickily.
module pc_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic [63:0]      NextPC,
  output logic [63:0]      CurrentPC,
  output logic             IMemReq,
  output logic [63:0]      IMemAddr,
  input  logic             IMemAck,
  input  logic [31:0]      IMemData,
  output logic [31:0]      Instr,
  output logic             InstrValid,
  input  logic             InstrReady,
  output logic             Fault,
  output logic [1:0]       FaultCause,
  output logic [CNT_W-1:0] RetiredCnt
);

  localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [63:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              req_q, req_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // The request is registered so it stays low throughout reset and rises
  // only on the first clock after release; acks are honoured only while it is high.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    wait_d  = wait_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      FETCH: begin
        if (req_q) begin
          if (IMemAck) begin
            instr_d = IMemData;
            wait_d  = '0;
            state_d = ISSUE;
          end else if (wait_q == WAIT_LAST) begin
            wait_d  = '0;
            cause_d = 2'b10;
            state_d = FAULT;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      ISSUE: begin
        if (InstrReady) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (NextPC[1:0] == 2'b00) begin
            pc_d    = NextPC;
            state_d = FETCH;
          end else begin
            cause_d = 2'b01;
            state_d = FAULT;
          end
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
    req_d = (state_d == FETCH);
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      req_q   <= 1'b0;
      wait_q  <= '0;
      cause_q <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      req_q   <= req_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  assign CurrentPC  = pc_q;
  assign IMemAddr   = pc_q;
  assign IMemReq    = req_q;
  assign Instr      = instr_q;
  assign InstrValid = (state_q == ISSUE);
  assign Fault      = (state_q == FAULT);
  assign FaultCause = cause_q;
  assign RetiredCnt = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a memory model pushes each acked word with its
// address, and every datapath consume pops and compares the issued instruction and PC.
module tb_pc_fetch_unit;

  logic        CLK;
  logic        Reset_L;
  logic [63:0] NextPC;
  logic [63:0] CurrentPC;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemData;
  logic [31:0] Instr;
  logic        InstrValid;
  logic        InstrReady;
  logic        Fault;
  logic [1:0]  FaultCause;
  logic [31:0] RetiredCnt;

  pc_fetch_unit #(
    .RESET_PC(64'h400),
    .TIMEOUT (16),
    .CNT_W   (32)
  ) dut (
    .CLK       (CLK),
    .Reset_L   (Reset_L),
    .NextPC    (NextPC),
    .CurrentPC (CurrentPC),
    .IMemReq   (IMemReq),
    .IMemAddr  (IMemAddr),
    .IMemAck   (IMemAck),
    .IMemData  (IMemData),
    .Instr     (Instr),
    .InstrValid(InstrValid),
    .InstrReady(InstrReady),
    .Fault     (Fault),
    .FaultCause(FaultCause),
    .RetiredCnt(RetiredCnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] exp_pc;
  logic [31:0] exp_cnt;
  int unsigned n_cmp;
  int unsigned n_bad;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_req();
    int unsigned n;
    n = 0;
    while (!IMemReq && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!IMemReq) chk("req_wait", 64'(IMemReq), 64'd1);
  endtask

  // One fetch/issue/consume round; InstrReady is driven high during the ack
  // wait to confirm it is ignored outside ISSUE.
  task automatic run_instr(input logic [63:0] nxt, input int unsigned lat,
                           input int unsigned stall, input logic [31:0] data);
    exp_t e;
    wait_req();
    chk("imem_addr", IMemAddr, exp_pc);
    for (int unsigned i = 0; i < lat; i++) begin
      InstrReady = 1'b1;
      @(negedge CLK);
      chk("addr_hold", IMemAddr, exp_pc);
    end
    InstrReady = 1'b0;
    IMemAck    = 1'b1;
    IMemData   = data;
    sb.push_back('{pc: exp_pc, ins: data});
    @(negedge CLK);
    IMemAck  = 1'b0;
    IMemData = $urandom;
    chk("valid", 64'(InstrValid), 64'd1);
    chk("req_drop", 64'(IMemReq), 64'd0);
    for (int unsigned i = 0; i < stall; i++) begin
      @(negedge CLK);
      chk("stall_instr", 64'(Instr), 64'(sb[0].ins));
      chk("stall_pc", CurrentPC, sb[0].pc);
    end
    NextPC     = nxt;
    InstrReady = 1'b1;
    e = sb.pop_front();
    chk("instr", 64'(Instr), 64'(e.ins));
    chk("issue_pc", CurrentPC, e.pc);
    @(negedge CLK);
    InstrReady = 1'b0;
    exp_cnt++;
    if (nxt[1:0] == 2'b00) exp_pc = nxt;
    chk("retired", 64'(RetiredCnt), 64'(exp_cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    Reset_L    = 1'b0;
    NextPC     = '0;
    IMemAck    = 1'b0;
    IMemData   = '0;
    InstrReady = 1'b0;
    exp_pc     = 64'h400;
    exp_cnt    = '0;

    repeat (2) @(negedge CLK);
    chk("rst_pc", CurrentPC, 64'h400);
    chk("rst_req", 64'(IMemReq), 64'd0);
    chk("rst_valid", 64'(InstrValid), 64'd0);
    chk("rst_fault", 64'(Fault), 64'd0);
    chk("rst_cause", 64'(FaultCause), 64'd0);
    chk("rst_cnt", 64'(RetiredCnt), 64'd0);
    chk("rst_instr", 64'(Instr), 64'd0);
    Reset_L = 1'b1;
    @(negedge CLK);
    chk("first_req", 64'(IMemReq), 64'd1);
    chk("first_addr", IMemAddr, 64'h400);

    for (int i = 0; i < 3; i++) run_instr(exp_pc + 64'd4, 0, 0, 32'hF84003E9);
    chk("seq_cnt", 64'(RetiredCnt), 64'd3);
    chk("seq_pc", CurrentPC, 64'h40C);

    run_instr(exp_pc + 64'd4, 3, 0, 32'h12345678);
    run_instr(exp_pc - 64'd8, 1, 5, 32'hDEADBEEF);
    chk("branch_pc", CurrentPC, 64'h408);

    run_instr(64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 32'hA5A5A5A5);
    run_instr(64'h0, 0, 0, 32'h5A5A5A5A);
    run_instr(64'h4, 2, 0, 32'h00000013);

    wait_req();
    @(negedge CLK);
    IMemAck = 1'b1;
    Reset_L = 1'b0;
    #1;
    chk("midrst_req", 64'(IMemReq), 64'd0);
    chk("midrst_pc", CurrentPC, 64'h400);
    chk("midrst_cnt", 64'(RetiredCnt), 64'd0);
    @(negedge CLK);
    Reset_L = 1'b1;
    @(negedge CLK);
    IMemAck = 1'b0;
    chk("stale_ack_valid", 64'(InstrValid), 64'd0);
    chk("rerun_req", 64'(IMemReq), 64'd1);
    chk("rerun_addr", IMemAddr, 64'h400);
    exp_pc  = 64'h400;
    exp_cnt = '0;

    run_instr(64'h402, 0, 0, 32'hCAFEF00D);
    chk("mis_fault", 64'(Fault), 64'd1);
    chk("mis_cause", 64'(FaultCause), 64'd1);
    chk("mis_pc", CurrentPC, 64'h400);
    IMemAck    = 1'b1;
    InstrReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("fault_req", 64'(IMemReq), 64'd0);
      chk("fault_valid", 64'(InstrValid), 64'd0);
      chk("fault_cause_hold", 64'(FaultCause), 64'd1);
    end
    chk("fault_cnt_hold", 64'(RetiredCnt), 64'd1);
    IMemAck    = 1'b0;
    InstrReady = 1'b0;

    Reset_L = 1'b0;
    @(negedge CLK);
    Reset_L = 1'b1;
    chk("to_rst_cause", 64'(FaultCause), 64'd0);
    wait_req();
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      if (i < 16) begin
        chk("to_early", 64'(Fault), 64'd0);
      end else begin
        chk("to_fault", 64'(Fault), 64'd1);
        chk("to_cause", 64'(FaultCause), 64'd2);
        chk("to_req", 64'(IMemReq), 64'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
